// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART core: FSM state encoding,
// oversampling constants, RX flag bit positions and the parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam int OVERSAMPLE = 16;
    localparam int MID_SAMPLE = 8;

    localparam int ERR_FRAME  = 0;
    localparam int ERR_PARITY = 1;

    // Callers zero-extend narrower words, which leaves the XOR unchanged.
    function automatic logic parity_bit(input logic [7:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with first-word fall-through output; a write into a full
// FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_rd = rd && !empty;
    assign do_wr = wr && (!full || do_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_fifo_core.sv
// UART with shared 16x baud tick, FIFO-buffered transmitter and receiver,
// configurable data width, parity and stop bits.
module uart_fifo_core
    import uart_pkg::*;
#(
    parameter int NBITS      = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [DIV_W-1:0] BaudDiv,
    input  logic             Rx,
    output logic             Tx,
    input  logic [NBITS-1:0] TxData,
    input  logic             TxWr,
    output logic             TxFull,
    output logic             TxBusy,
    output logic [NBITS-1:0] RxData,
    output logic [1:0]       RxErr,
    output logic             RxEmpty,
    input  logic             RxRd,
    output logic             RxOverrun
);

    localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE - 1);
    localparam logic [2:0] LAST_DATA = 3'(NBITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic       ODD       = (PARITY_ODD != 0);

    logic [DIV_W-1:0] baud_cnt;
    logic             tick;

    assign tick = (baud_cnt >= BaudDiv);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) baud_cnt <= '0;
        else        baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
    end

    uart_state_e      tx_state;
    uart_state_e      tx_next;
    logic [3:0]       tx_tick_cnt;
    logic [2:0]       tx_bit_cnt;
    logic [NBITS-1:0] tx_shift;
    logic             tx_par;
    logic             tx_pop;
    logic             tx_bit_end;
    logic             tx_fifo_empty;
    logic [NBITS-1:0] tx_fifo_dout;

    uart_sync_fifo #(.WIDTH(NBITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk   (Clk),
        .rst_n (Rst_n),
        .wr    (TxWr),
        .rd    (tx_pop),
        .din   (TxData),
        .dout  (tx_fifo_dout),
        .full  (TxFull),
        .empty (tx_fifo_empty)
    );

    assign tx_bit_end = tick && (tx_tick_cnt == LAST_TICK);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) tx_state <= IDLE;
        else        tx_state <= tx_next;
    end

    // Leaving IDLE only on a tick keeps every bit exactly 16 ticks long.
    always_comb begin
        tx_next = tx_state;
        tx_pop  = 1'b0;
        case (tx_state)
            IDLE: begin
                if (tick && !tx_fifo_empty) begin
                    tx_next = START;
                    tx_pop  = 1'b1;
                end
            end
            START:  if (tx_bit_end) tx_next = DATA;
            DATA: begin
                if (tx_bit_end && tx_bit_cnt == LAST_DATA)
                    tx_next = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: if (tx_bit_end) tx_next = STOP;
            STOP: begin
                if (tx_bit_end && tx_bit_cnt == LAST_STOP) begin
                    if (!tx_fifo_empty) begin
                        tx_next = START;
                        tx_pop  = 1'b1;
                    end else begin
                        tx_next = IDLE;
                    end
                end
            end
            default: tx_next = IDLE;
        endcase
    end

    always_comb begin
        TxBusy = (tx_state != IDLE);
        case (tx_state)
            START:   Tx = 1'b0;
            DATA:    Tx = tx_shift[0];
            PARITY:  Tx = tx_par;
            default: Tx = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
        end else if (tx_next != tx_state) begin
            tx_tick_cnt <= '0;
            tx_bit_cnt  <= '0;
        end else if (tick) begin
            tx_tick_cnt <= tx_tick_cnt + 1'b1;
            if (tx_bit_end) tx_bit_cnt <= tx_bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (tx_pop) begin
            tx_shift <= tx_fifo_dout;
            tx_par   <= parity_bit(8'(tx_fifo_dout), ODD);
        end else if (tx_state == DATA && tx_bit_end) begin
            tx_shift <= tx_shift >> 1;
        end
    end

    uart_state_e      rx_state;
    uart_state_e      rx_next;
    logic             rx_s1;
    logic             rx_s2;
    logic             rx_prev;
    logic             rx_fall;
    logic [3:0]       rx_tick_cnt;
    logic [2:0]       rx_bit_cnt;
    logic [NBITS-1:0] rx_shift;
    logic             rx_perr;
    logic             rx_samp;
    logic             rx_mid;
    logic             rx_push;
    logic [1:0]       rx_flags;
    logic             rx_full;
    logic [NBITS+1:0] rx_fifo_dout;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= Rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    assign rx_fall = rx_prev && !rx_s2;
    assign rx_samp = tick && (rx_tick_cnt == LAST_TICK);
    assign rx_mid  = tick && (rx_tick_cnt == MID_TICK);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) rx_state <= IDLE;
        else        rx_state <= rx_next;
    end

    // The START mid-point restarts the tick count, so later samples land mid-bit.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            IDLE:   if (rx_fall) rx_next = START;
            START:  if (rx_mid) rx_next = rx_s2 ? IDLE : DATA;
            DATA: begin
                if (rx_samp && rx_bit_cnt == LAST_DATA)
                    rx_next = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: if (rx_samp) rx_next = STOP;
            STOP:   if (rx_samp) rx_next = IDLE;
            default: rx_next = IDLE;
        endcase
    end

    always_comb begin
        rx_push              = (rx_state == STOP) && rx_samp;
        rx_flags             = '0;
        rx_flags[ERR_FRAME]  = ~rx_s2;
        rx_flags[ERR_PARITY] = rx_perr;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rx_tick_cnt <= '0;
            rx_bit_cnt  <= '0;
            rx_perr     <= 1'b0;
            RxOverrun   <= 1'b0;
        end else begin
            if (rx_next != rx_state) begin
                rx_tick_cnt <= '0;
                rx_bit_cnt  <= '0;
            end else if (tick) begin
                rx_tick_cnt <= rx_tick_cnt + 1'b1;
                if (rx_samp) rx_bit_cnt <= rx_bit_cnt + 1'b1;
            end
            if (rx_state == IDLE)
                rx_perr <= 1'b0;
            else if (rx_state == PARITY && rx_samp)
                rx_perr <= rx_s2 ^ parity_bit(8'(rx_shift), ODD);
            RxOverrun <= rx_push && rx_full && !RxRd;
        end
    end

    always_ff @(posedge Clk) begin
        if (rx_state == DATA && rx_samp) rx_shift <= {rx_s2, rx_shift[NBITS-1:1]};
    end

    uart_sync_fifo #(.WIDTH(NBITS + 2), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk   (Clk),
        .rst_n (Rst_n),
        .wr    (rx_push),
        .rd    (RxRd),
        .din   ({rx_flags, rx_shift}),
        .dout  (rx_fifo_dout),
        .full  (rx_full),
        .empty (RxEmpty)
    );

    // Storage is not reset, so the head is masked to zero while empty.
    assign RxData = RxEmpty ? '0 : rx_fifo_dout[NBITS-1:0];
    assign RxErr  = RxEmpty ? '0 : rx_fifo_dout[NBITS+1:NBITS];

endmodule

// File: doc/uart_fifo_core.md
Name: uart_fifo_core

Overview:
- Parametrised successor to the fixed 8N1 UART top.
- Contains a shared 16x-oversampling baud tick generator, a transmitter and a receiver. Data width, parity and stop bits are configurable.
- TX and RX each have a FIFO, with a write/pop handshake toward the user logic.
- Per-word framing and parity error flags travel with the RX data. RX overrun is reported.
- Sits between the Bluetooth module pins (HC-06) and the application logic.

Parameters:
- NBITS, 8, data bits per frame (5..8), sent LSB first.
- PARITY_EN, 0, 1 inserts a parity bit after the data bits.
- PARITY_ODD, 0, 1 selects odd parity, 0 selects even (used only when PARITY_EN=1).
- STOP_BITS, 1, number of stop bits (1 or 2).
- FIFO_DEPTH, 16, entries per FIFO; must be a power of 2, at least 2.
- DIV_W, 16, width of the baud divisor.

Ports:
- Clk  in  1  system clock
- Rst_n  in  1  asynchronous active-low reset
- BaudDiv  in  DIV_W  tick period minus 1 (50 MHz, 9600 baud gives 325)
- Rx  in  1  serial input, asynchronous to Clk
- Tx  out  1  serial output, idle high
- TxData  in  NBITS  word to enqueue
- TxWr  in  1  enqueue strobe, one word per cycle
- TxFull  out  1  TX FIFO full
- TxBusy  out  1  transmitter not in IDLE
- RxData  out  NBITS  head of RX FIFO (first-word fall-through)
- RxErr  out  2  head-word flags: bit 0 framing error, bit 1 parity error
- RxEmpty  out  1  RX FIFO empty; RxData/RxErr valid only when 0
- RxRd  in  1  pop strobe
- RxOverrun  out  1  one-cycle pulse when a received word is dropped

Behaviour:
- Reset (async assert, sync release): Tx=1, TxBusy=0, TxFull=0, RxEmpty=1, RxData=0, RxErr=0, RxOverrun=0. Both FIFOs are emptied, both FSMs go to IDLE and the tick counter goes to 0. A reset mid-frame aborts the frame and Tx returns high immediately.
- Tick generator:
  - Counter increments each Clk. When count >= BaudDiv it emits a one-cycle tick and reloads 0.
  - BaudDiv=0 gives a tick every cycle.
  - A BaudDiv change takes effect at once; the >= compare prevents runaway.
- Bit period is 16 ticks.
- TX FIFO:
  - TxWr while full (no pop the same cycle) is dropped.
  - Write and pop in the same cycle while full are both accepted.
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - IDLE with FIFO non-empty: pop, load shifter, reset tick count, enter START.
  - START drives Tx=0 for 16 ticks.
  - DATA shifts NBITS bits LSB first, 16 ticks each.
  - PARITY (only if PARITY_EN) sends XOR of data, inverted if PARITY_ODD.
  - STOP drives Tx=1 for 16*STOP_BITS ticks.
  - At the end of STOP: if the FIFO is non-empty, pop and go straight to START (no idle gap); else IDLE.
- RX path:
  - Rx passes through a 2-flop synchroniser.
  - IDLE arms on a synchronised 1->0 transition.
  - START: after 8 ticks resample. If high, this is a false start: return to IDLE with nothing pushed.
  - DATA: sample every 16 ticks (mid-bit), shift LSB first.
  - PARITY: compare the sampled bit with the expected value; a mismatch sets the parity flag.
  - STOP: sample once, 16 ticks after the last bit. 0 sets the framing flag.
  - After the stop sample, push {flags, data} into the RX FIFO and return to IDLE in the same cycle, so the next start edge is accepted immediately. With STOP_BITS=2 the receiver checks only the first stop bit.
- A break (line held low) produces one word with the framing flag. No new frame starts until a fresh 1->0 edge.
- RX FIFO:
  - Push while full (no pop the same cycle): word discarded, RxOverrun pulses for 1 cycle, FIFO contents unchanged.
  - RxRd while empty is ignored.
  - Push and pop in the same cycle on a non-empty FIFO keep the count unchanged.
- Latency: RxEmpty falls 1 Clk after the stop-sample cycle.
- Parity arithmetic is reduction XOR over NBITS bits only.

Decomposition:
- Shared package uart_pkg holds:
  - RX/TX state encodings (localparam enum: IDLE, START, DATA, PARITY, STOP)
  - OVERSAMPLE=16
  - MID_SAMPLE=8
  - RX error bit indices
- One natural sub-module: uart_sync_fifo (parameters WIDTH, DEPTH; ports wr, rd, din, dout, full, empty). Instantiate it twice: TX with WIDTH=NBITS, RX with WIDTH=NBITS+2.
- Tick generator, TX FSM and RX FSM stay inline.

Test Plan:
- 8N1, BaudDiv=3, write 0x55 then 0xA3 on consecutive cycles -> Tx shows two back-to-back frames of 16*4*10=640 Clk each with no idle gap. TxBusy is high for exactly 1280 Clk.
- Loop Tx to Rx, PARITY_EN=1 even, write 0x00, 0xFF, 0x81 -> RX FIFO yields the same three words in order, RxErr=0.
- Drive a frame with a wrong parity bit, then a frame with stop=0 -> RxErr=2'b10 on the first word and 2'b01 on the second.
- Glitch Rx low for 4 ticks only -> no word pushed, RxEmpty stays 1.
- Send FIFO_DEPTH+1 frames with no RxRd -> exactly one RxOverrun pulse. The FIFO then holds the first 16 words, and the 17th is lost.
- Assert Rst_n=0 mid-DATA on TX -> Tx=1 asynchronously and TxBusy=0. After release, the FIFO is empty and no frame resumes.
